mem_access: RTL

- Memory stage directly downstream of the execute stage (via the ex/mem pipeline register).
- Consumes the execute stage's result bundle: we, waddr, wdata, aluop, mem_addr, reg2.
- For loads and stores, runs a req/ack transaction on the data-RAM port, stalling the pipeline until the transaction completes.
- Produces the write-back bundle for the mem/wb register.

---
 rtl/mem_access_if.sv | 33 +++
 rtl/mem_access.sv | 123 ++++++++++++
 2 files changed

// File: rtl/mem_access_if.sv
// Data-RAM port between the memory stage (master) and the data RAM (slave).
// A request is raised in ram_req_o and completed by a one-cycle ram_ack_i pulse.
interface mem_access_if #(
  parameter int DATA_W = 32
);
  logic              ram_req_o;
  logic              ram_we_o;
  logic [3:0]        ram_be_o;
  logic [31:0]       ram_addr_o;
  logic [DATA_W-1:0] ram_wdata_o;
  logic [DATA_W-1:0] ram_rdata_i;
  logic              ram_ack_i;

  modport master (
    output ram_req_o,
    output ram_we_o,
    output ram_be_o,
    output ram_addr_o,
    output ram_wdata_o,
    input  ram_rdata_i,
    input  ram_ack_i
  );

  modport slave (
    input  ram_req_o,
    input  ram_we_o,
    input  ram_be_o,
    input  ram_addr_o,
    input  ram_wdata_o,
    output ram_rdata_i,
    output ram_ack_i
  );
endinterface

// File: rtl/mem_access.sv
// Memory stage: runs a req/ack RAM transaction for loads/stores while stalling
// upstream, and forms the write-back bundle for the mem/wb register.
module mem_access #(
  parameter int         DATA_W = 32,
  parameter logic [4:0] LB_OP  = 5'h10,
  parameter logic [4:0] LW_OP  = 5'h11,
  parameter logic [4:0] SB_OP  = 5'h12,
  parameter logic [4:0] SW_OP  = 5'h13
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_i,
  input  logic              we_i,
  input  logic [4:0]        waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [4:0]        aluop_i,
  input  logic [31:0]       mem_addr_i,
  input  logic [DATA_W-1:0] reg2_i,
  output logic              we_o,
  output logic [4:0]        waddr_o,
  output logic [DATA_W-1:0] wdata_o,
  output logic              stall_from_mem,
  output logic              err_o,
  mem_access_if.master      ram
);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  state_t            state;
  logic [DATA_W-1:0] load_q;

  logic is_lb, is_lw, is_sb, is_sw;
  logic is_load, is_store, is_mem, misaligned, aligned_mem;

  // Little-endian byte lane select with sign extension for LB.
  function automatic logic [DATA_W-1:0] load_byte(input logic [DATA_W-1:0] word,
                                                  input logic [1:0] lane);
    logic signed [7:0] b;
    b = word[8*lane +: 8];
    return {{(DATA_W-8){b[7]}}, b};
  endfunction

  always_comb begin
    is_lb       = (aluop_i == LB_OP);
    is_lw       = (aluop_i == LW_OP);
    is_sb       = (aluop_i == SB_OP);
    is_sw       = (aluop_i == SW_OP);
    is_load     = is_lb || is_lw;
    is_store    = is_sb || is_sw;
    is_mem      = valid_i && (is_load || is_store);
    // Only word accesses can be misaligned; byte accesses pick a lane instead.
    misaligned  = is_mem && (is_lw || is_sw) && (mem_addr_i[1:0] != 2'b00);
    aligned_mem = is_mem && !misaligned;
  end

  // Transaction FSM; RAM port fields are latched on IDLE->REQ and held until done.
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      ram.ram_req_o   <= 1'b0;
      ram.ram_we_o    <= 1'b0;
      ram.ram_be_o    <= 4'h0;
      ram.ram_addr_o  <= '0;
      ram.ram_wdata_o <= '0;
      load_q          <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (aligned_mem) begin
            state          <= REQ;
            ram.ram_req_o  <= 1'b1;
            ram.ram_we_o   <= is_store;
            ram.ram_addr_o <= {mem_addr_i[31:2], 2'b00};
            if (is_sb) begin
              ram.ram_be_o    <= 4'b0001 << mem_addr_i[1:0];
              ram.ram_wdata_o <= {(DATA_W/8){reg2_i[7:0]}};
            end else begin
              ram.ram_be_o    <= 4'hF;
              ram.ram_wdata_o <= reg2_i;
            end
          end
        end
        REQ: begin
          if (ram.ram_ack_i) begin
            state         <= DONE;
            ram.ram_req_o <= 1'b0;
            load_q        <= is_lb ? load_byte(ram.ram_rdata_i, mem_addr_i[1:0])
                                   : ram.ram_rdata_i;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Write-back bundle: bubble while a memory op is in progress.
  always_comb begin
    we_o           = 1'b0;
    wdata_o        = wdata_i;
    stall_from_mem = 1'b0;
    err_o          = 1'b0;
    waddr_o        = waddr_i;
    if (rst) begin
      wdata_o = '0;
    end else begin
      case (state)
        IDLE: begin
          stall_from_mem = aligned_mem;
          err_o          = misaligned;
          we_o           = we_i && valid_i && !is_mem;
        end
        REQ:  stall_from_mem = 1'b1;
        DONE: begin
          we_o    = we_i;
          wdata_o = is_load ? load_q : wdata_i;
        end
        default: ;
      endcase
    end
  end

endmodule
